uart_rx_os: RTL and testbench

Parametrised 16x-oversampling UART receiver, the next-generation replacement for the fixed 8-bit, fixed-baud receiver in the serial subsystem. It supports runtime baud divisor, configurable data width, none/even/odd parity, and 1 or 2 stop bits. It reports parity, framing, break and overrun conditions, and presents each frame through a valid/ready holding register to the downstream consumer (FIFO or register bank).

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_os.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: oversampling constants, parity encodings and receiver FSM states.
// Build option UART_RX_MAJORITY_EN enables the 2-of-3 mid-bit voter constants.
package uart_pkg;

  localparam int OS_RATE = 16;
  localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);
  localparam logic [3:0] MID_SAMPLE = 4'd8;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] MID_EARLY = 4'd7;
  localparam logic [3:0] MID_LATE = 4'd9;
  localparam logic [3:0] DECIDE_POS = MID_LATE;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction
`else
  localparam logic [3:0] DECIDE_POS = MID_SAMPLE;
`endif

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick divider, one tick every div+1 enabled clocks.
// Shared between the oversampled receiver and the future transmitter.
module uart_baud_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && !clr && (cnt == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at os_cnt 7/8/9.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_prev;

  rx_state_e state_q;
  rx_state_e state_d;

  logic [DIV_W-1:0]     div_q;
  logic [1:0]           pmode_q;
  logic                 stop2_q;
  logic [3:0]           os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 fe_q;

  logic tick;
  logic start_det;
  logic par_en;
  logic decide;
  logic bit_end;
  logic sample;
  logic frame_done;
  logic fe_now;
  logic pe_now;
  logic bd_now;

  assign rxs = sync_q[SYNC_STAGES-1];
  assign busy = (state_q != IDLE);
  assign start_det = (state_q == IDLE) && rxs_prev && !rxs;
  assign par_en = (pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD);
  assign decide = tick && (os_cnt == DECIDE_POS);
  assign bit_end = tick && (os_cnt == OS_LAST);

`ifdef UART_RX_MAJORITY_EN
  logic s_early;
  logic s_mid;
  assign sample = maj3(s_early, s_mid, rxs);
`else
  assign sample = rxs;
`endif

  uart_baud_tick #(.W(DIV_W)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == IDLE),
    .en   (state_q != IDLE),
    .div  (div_q),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '1;
      rxs_prev <= 1'b1;
      state_q  <= IDLE;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev <= rxs;
      state_q  <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    fe_now     = fe_q;
    unique case (state_q)
      IDLE: begin
        if (start_det) state_d = START;
      end
      START: begin
        if (decide && sample) state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == LAST_BIT)
          state_d = par_en ? PARITY : STOP1;
      end
      PARITY: begin
        if (bit_end) state_d = STOP1;
      end
      STOP1: begin
        if (decide) begin
          fe_now = fe_q | ~sample;
          if (!stop2_q) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end else if (bit_end) begin
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (decide) begin
          fe_now     = fe_q | ~sample;
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Odd mode wants XOR(data, parity) = 1, even mode wants 0.
  assign pe_now = par_en &&
    ((^shreg ^ par_q) != (pmode_q == PAR_ODD));
  assign bd_now = fe_now && (shreg == '0) &&
    !(par_en && par_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      pmode_q <= PAR_NONE;
      stop2_q <= 1'b0;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      if (start_det) begin
        div_q   <= baud_div;
        pmode_q <= parity_mode;
        stop2_q <= stop2;
        bit_cnt <= '0;
        fe_q    <= 1'b0;
      end
      if (state_q == IDLE) os_cnt <= '0;
      else if (tick) os_cnt <= bit_end ? 4'd0 : os_cnt + 4'd1;
      if (state_q == DATA && decide)
        shreg <= {sample, shreg[DATA_BITS-1:1]};
      if (state_q == DATA && bit_end)
        bit_cnt <= bit_cnt + 4'd1;
      if (state_q == PARITY && decide) par_q <= sample;
      if (state_q == STOP1 && decide) fe_q <= fe_now;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (tick && os_cnt == MID_EARLY) s_early <= rxs;
      if (tick && os_cnt == MID_SAMPLE) s_mid <= rxs;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_det     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!data_valid || data_ready) begin
          data_out      <= shreg;
          parity_error  <= pe_now;
          framing_error <= fe_now;
          break_det     <= bd_now;
          data_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scenario tasks plus randomized frames against a frame-level model.
// Honours UART_RX_MAJORITY_EN for decision timing and the glitch scenario.
`timescale 1ns/1ps
module tb_uart_rx_os;

`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = 9;
`else
  localparam int DEC = 8;
`endif

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
    int         rise;
  } frm_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        parity_error;
  logic        framing_error;
  logic        break_det;
  logic        overrun;
  logic        busy;

  uart_rx_os #(.DATA_BITS(8), .DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .baud_div(baud_div),
    .parity_mode(parity_mode), .stop2(stop2), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready),
    .parity_error(parity_error), .framing_error(framing_error),
    .break_det(break_det), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_rise = 0;
  int   ovr_cnt = 0;
  logic dv_prev = 1'b0;
  frm_t got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #1;
    if (data_valid && !dv_prev) last_rise = cyc;
    dv_prev = data_valid;
    if (data_valid && data_ready)
      got.push_back('{data_out, parity_error, framing_error, break_det, last_rise});
    if (overrun) ovr_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic frm_t model(input logic [7:0] d, input logic [1:0] pm,
                                 input logic pb, input logic sa,
                                 input logic sb, input logic s2);
    frm_t m;
    logic pen;
    pen = (pm == 2'b01) || (pm == 2'b10);
    m.data = d;
    m.fe = !sa || (s2 && !sb);
    m.pe = pen && (((^d) ^ pb) != (pm == 2'b10));
    m.bd = m.fe && (d == 8'h00) && !(pen && pb);
    m.rise = 0;
    return m;
  endfunction

  function automatic int exp_lat(input int div, input logic [1:0] pm, input logic s2);
    int nb;
    nb = 10 + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0) + (s2 ? 1 : 0);
    return 3 + (div + 1) * (16 * (nb - 1) + DEC + 1);
  endfunction

  // Drives one frame plus one idle bit; config inputs are scrambled mid-frame.
  task automatic send_frame(input logic [7:0] d, input int div, input logic [1:0] pm,
                            input logic s2, input logic pb, input logic sa,
                            input logic sb, input int max_cyc, input int ready_at,
                            input int glitch_at);
    logic fb[$];
    int bl;
    int n;
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(d[i]);
    if (pm == 2'b01 || pm == 2'b10) fb.push_back(pb);
    fb.push_back(sa);
    if (s2) fb.push_back(sb);
    bl = 16 * (div + 1);
    n = (fb.size() + 1) * bl;
    @(negedge clk);
    baud_div = 16'(div);
    parity_mode = pm;
    stop2 = s2;
    for (int i = 0; i < n && i < max_cyc; i++) begin
      @(negedge clk);
      if (i == 0) start_cyc = cyc;
      rx = (i / bl < fb.size()) ? fb[i / bl] : 1'b1;
      if (i == glitch_at) rx = ~rx;
      if (i == ready_at) data_ready = 1'b1;
      if (i == 2 * bl) begin
        baud_div = 16'(div + 3);
        parity_mode = ~pm;
        stop2 = ~s2;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    data_ready = 1'b1;
    baud_div = 16'd0;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data got=%0h exp=0", data_out); end
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", data_valid); end
    checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL rst_pe got=%0b exp=0", parity_error); end
    checks++; if (framing_error !== 1'b0) begin failures++; $display("FAIL rst_fe got=%0b exp=0", framing_error); end
    checks++; if (break_det !== 1'b0) begin failures++; $display("FAIL rst_bd got=%0b exp=0", break_det); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_ovr got=%0b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean();
    int o0;
    o0 = ovr_cnt;
    got.delete();
    send_frame(8'hA5, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 100000, -1, -1);
    checks++; if (got.size() !== 1) begin failures++; $display("FAIL clean_count got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0].data !== 8'hA5) begin failures++; $display("FAIL clean_data got=%0h exp=a5", got[0].data); end
      checks++; if ({got[0].pe, got[0].fe, got[0].bd} !== 3'b000) begin failures++; $display("FAIL clean_flags got=%0b exp=000", {got[0].pe, got[0].fe, got[0].bd}); end
      checks++; if (got[0].rise - start_cyc !== exp_lat(0, 2'b00, 1'b0)) begin failures++; $display("FAIL clean_latency got=%0d exp=%0d", got[0].rise - start_cyc, exp_lat(0, 2'b00, 1'b0)); end
    end
    checks++; if (ovr_cnt !== o0) begin failures++; $display("FAIL clean_overrun got=%0d exp=%0d", ovr_cnt, o0); end
  endtask

  task automatic test_parity();
    frm_t e;
    for (int m = 1; m <= 2; m++) begin
      got.delete();
      e = model(8'h3C, 2'(m), 1'b1, 1'b1, 1'b1, 1'b0);
      send_frame(8'h3C, 0, 2'(m), 1'b0, 1'b1, 1'b1, 1'b1, 100000, -1, -1);
      checks++; if (got.size() !== 1) begin failures++; $display("FAIL parity_count mode=%0d got=%0d exp=1", m, got.size()); end
      if (got.size() > 0) begin
        checks++; if (got[0].data !== e.data) begin failures++; $display("FAIL parity_data mode=%0d got=%0h exp=%0h", m, got[0].data, e.data); end
        checks++; if (got[0].pe !== e.pe) begin failures++; $display("FAIL parity_err mode=%0d got=%0b exp=%0b", m, got[0].pe, e.pe); end
        checks++; if (got[0].fe !== 1'b0) begin failures++; $display("FAIL parity_fe mode=%0d got=%0b exp=0", m, got[0].fe); end
      end
    end
  endtask

  task automatic test_framing();
    got.delete();
    send_frame(8'h55, 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 100000, -1, -1);
    send_frame(8'h55, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 100000, -1, -1);
    checks++; if (got.size() !== 2) begin failures++; $display("FAIL framing_count got=%0d exp=2", got.size()); end
    if (got.size() > 1) begin
      checks++; if ({got[0].data, got[0].fe, got[0].bd} !== {8'h55, 2'b10}) begin failures++; $display("FAIL framing_first got=%0h/%0b/%0b exp=55/1/0", got[0].data, got[0].fe, got[0].bd); end
      checks++; if ({got[1].data, got[1].pe, got[1].fe, got[1].bd} !== {8'h55, 3'b000}) begin failures++; $display("FAIL framing_second got=%0h/%0b exp=55/000", got[1].data, {got[1].pe, got[1].fe, got[1].bd}); end
    end
  endtask

  task automatic test_break();
    got.delete();
    baud_div = 16'd0;
    parity_mode = 2'b00;
    stop2 = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (20 * 16) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    checks++; if (got.size() !== 1) begin failures++; $display("FAIL break_count got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      checks++; if ({got[0].data, got[0].fe, got[0].bd} !== {8'h00, 2'b11}) begin failures++; $display("FAIL break_frame got=%0h/%0b/%0b exp=0/1/1", got[0].data, got[0].fe, got[0].bd); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    got.delete();
    data_ready = 1'b0;
    send_frame(8'h11, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 100000, -1, -1);
    send_frame(8'h22, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 100000, -1, -1);
    #1;
    checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt - o0); end
    checks++; if ({data_valid, data_out} !== {1'b1, 8'h11}) begin failures++; $display("FAIL ovr_hold got=%0b/%0h exp=1/11", data_valid, data_out); end
    checks++; if (got.size() !== 0) begin failures++; $display("FAIL ovr_early_accept got=%0d exp=0", got.size()); end
    send_frame(8'h22, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 100000,
               exp_lat(0, 2'b00, 1'b0) - 1, -1);
    checks++; if (got.size() !== 2) begin failures++; $display("FAIL ovr_accept_count got=%0d exp=2", got.size()); end
    if (got.size() > 1) begin
      checks++; if ({got[0].data, got[1].data} !== 16'h1122) begin failures++; $display("FAIL ovr_order got=%0h,%0h exp=11,22", got[0].data, got[1].data); end
    end
    checks++; if (ovr_cnt - o0 !== 1) begin failures++; $display("FAIL ovr_same_cycle got=%0d exp=1", ovr_cnt - o0); end
    data_ready = 1'b1;
  endtask

  task automatic test_glitch();
    int len;
    for (int k = 0; k < 4; k++) begin
      got.delete();
      len = (k == 0) ? 7 : int'($urandom_range(1, 7));
      @(negedge clk);
      rx = 1'b0;
      repeat (len) @(negedge clk);
      rx = 1'b1;
      repeat (48) @(negedge clk);
      checks++; if (got.size() !== 0) begin failures++; $display("FAIL glitch_output len=%0d got=%0d exp=0", len, got.size()); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy len=%0d got=%0b exp=0", len, busy); end
    end
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b0;
    send_frame(8'h5A, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 100000, -1, -1);
    send_frame(8'h7E, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16 * 4, -1, -1);
    reset = 1'b1;
    rx = 1'b1;
    #1;
    checks++; if ({data_valid, data_out} !== 9'h000) begin failures++; $display("FAIL rstmid_data got=%0b/%0h exp=0/0", data_valid, data_out); end
    checks++; if ({busy, parity_error, framing_error, break_det, overrun} !== 5'b0) begin failures++; $display("FAIL rstmid_flags got=%0b exp=0", {busy, parity_error, framing_error, break_det, overrun}); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    data_ready = 1'b1;
    got.delete();
    repeat (4) @(negedge clk);
    send_frame(8'h7E, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 100000, -1, -1);
    checks++; if (got.size() !== 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      checks++; if ({got[0].data, got[0].pe, got[0].fe, got[0].bd} !== {8'h7E, 3'b000}) begin failures++; $display("FAIL rstmid_frame got=%0h/%0b exp=7e/000", got[0].data, {got[0].pe, got[0].fe, got[0].bd}); end
    end
  endtask

  task automatic test_random();
    frm_t e;
    logic [7:0] d;
    logic [1:0] pm;
    logic s2, pb, sa, sb;
    int div;
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pm = 2'($urandom_range(0, 3));
      s2 = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      sa = ($urandom_range(0, 3) != 0);
      sb = ($urandom_range(0, 3) != 0);
      div = int'($urandom_range(0, 2));
      e = model(d, pm, pb, sa, sb, s2);
      got.delete();
      send_frame(d, div, pm, s2, pb, sa, sb, 100000, -1, -1);
      checks++; if (got.size() !== 1) begin failures++; $display("FAIL rand_count n=%0d got=%0d exp=1", n, got.size()); end
      if (got.size() > 0) begin
        checks++;
        if ({got[0].data, got[0].pe, got[0].fe, got[0].bd} !== {e.data, e.pe, e.fe, e.bd}) begin
          failures++;
          $display("FAIL rand_frame n=%0d got=%0h/%0b exp=%0h/%0b", n, got[0].data,
                   {got[0].pe, got[0].fe, got[0].bd}, e.data, {e.pe, e.fe, e.bd});
        end
        checks++;
        if (got[0].rise - start_cyc !== exp_lat(div, pm, s2)) begin
          failures++;
          $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, got[0].rise - start_cyc, exp_lat(div, pm, s2));
        end
      end
    end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    got.delete();
    send_frame(8'hA5, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 100000, -1, 9 + 16 * 4);
    checks++; if (got.size() !== 1) begin failures++; $display("FAIL maj_count got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0].data !== 8'hA5) begin failures++; $display("FAIL maj_data got=%0h exp=a5", got[0].data); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_parity();
    test_framing();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_mid();
    test_random();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
